// File: rtl/rx_uart.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, single holding register or FIFO.
// Define UART_RX_FIFO_EN to buffer received bytes in a FIFO_DEPTH-entry FIFO instead of one register.
`timescale 1ns/1ps

module rx_uart #(
    parameter int SYSTEM_CLK = 90_000_000,
    parameter int BAUDRATE   = 2_000_000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    // state | meaning
    // IDLE  | line idle, hunting for a falling edge
    // START | waiting half a bit to confirm the start bit
    // DATA  | sampling 8 data bits, LSB first
    // STOP  | sampling the stop bit
    // BREAK | stop bit was low; wait for the line to return high
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    localparam int CYCLES_PER_BIT = SYSTEM_CLK / BAUDRATE;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CW             = $clog2(CYCLES_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_TC = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_TC  = CW'(CYCLES_PER_BIT - 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rx_uart: FIFO_DEPTH must be a power of two >= 2");
    end

    state_t        state, state_nxt;
    logic          sync1, rx_s;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          push, ferr_set, pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            sync1     <= rx_in;
            rx_s      <= sync1;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shreg     <= shreg_nxt;
            frame_err <= ferr_set;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        push        = 1'b0;
        ferr_set    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (cnt == HALF_TC) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt   = DATA;
                        bit_idx_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == BIT_TC) begin
                    cnt_nxt            = '0;
                    shreg_nxt[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                    else                 bit_idx_nxt = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt == BIT_TC) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_set  = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_nxt = '0;
                if (rx_s) state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign pop = valid && ready;

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic        empty, full;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign valid   = !empty;
    assign rx_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            overrun <= push && full && !pop;
            // a pop in the same cycle frees the slot the push needs
            if (push && (!full || pop)) begin
                mem[wptr[AW-1:0]] <= shreg;
                wptr              <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
        end
    end
`else
    logic [7:0] hold;
    logic       full_q;

    assign valid   = full_q;
    assign rx_data = hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold    <= '0;
            full_q  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && full_q && !pop;
            if (push && (!full_q || pop)) begin
                hold   <= shreg;
                full_q <= 1'b1;
            end else if (pop) begin
                full_q <= 1'b0;
            end
        end
    end
`endif

endmodule
